// File: rtl/deserializer.sv
// Serial-to-parallel front end: assembles flagged bits MSB-first into a MSG_SIZE-bit word,
// holds the completed word until released, and flags framing gaps and overruns.
module deserializer #(
  parameter int MSG_SIZE = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        iData_in,
  input  logic                        iData_flag,
  input  logic                        iRelease,
  output logic [MSG_SIZE-1:0]         oData_out,
  output logic [$clog2(MSG_SIZE):0]   oCounter,
  output logic                        oFull,
  output logic                        oFrame_err,
  output logic                        oOverflow
);

  localparam int CW = $clog2(MSG_SIZE) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MSG_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [MSG_SIZE-1:0] data_q,  data_d;
  logic [CW-1:0]       cnt_q,   cnt_d;
  logic                full_q,  full_d;
  logic                ferr_q,  ferr_d;
  logic                ovf_q,   ovf_d;

  logic [MSG_SIZE-1:0] data_shift;
  logic [CW-1:0]       cnt_inc;

  assign data_shift = {data_q[MSG_SIZE-2:0], iData_in};
  assign cnt_inc    = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  // The frame-error flag is a pulse, so it is the one register that does not
  // hold while disabled: it drops to zero on any edge with ena low.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    ferr_d  = 1'b0;
    ovf_d   = ovf_q;

    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (iData_flag) begin
            data_d  = data_shift;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end

        SHIFT: begin
          if (iData_flag) begin
            data_d = data_shift;
            cnt_d  = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              full_d  = 1'b1;
              state_d = FULL;
            end
          end else begin
            ferr_d  = 1'b1;
            data_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end

        FULL: begin
          if (iRelease) begin
            full_d = 1'b0;
            ovf_d  = 1'b0;
            if (iData_flag) begin
              data_d  = {{(MSG_SIZE-1){1'b0}}, iData_in};
              cnt_d   = CW'(1);
              state_d = SHIFT;
            end else begin
              data_d  = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else if (iData_flag) begin
            ovf_d = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
          full_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  assign oData_out  = data_q;
  assign oCounter   = cnt_q;
  assign oFull      = full_q;
  assign oFrame_err = ferr_q;
  assign oOverflow  = ovf_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer with MSG_SIZE=8; expected values are hand-computed.
module tb_deserializer;

  localparam int MSG_SIZE = 8;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       iData_in;
  logic       iData_flag;
  logic       iRelease;
  logic [7:0] oData_out;
  logic [3:0] oCounter;
  logic       oFull;
  logic       oFrame_err;
  logic       oOverflow;

  int checks   = 0;
  int failures = 0;

  deserializer #(.MSG_SIZE(MSG_SIZE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .iData_in   (iData_in),
    .iData_flag (iData_flag),
    .iRelease   (iRelease),
    .oData_out  (oData_out),
    .oCounter   (oCounter),
    .oFull      (oFull),
    .oFrame_err (oFrame_err),
    .oOverflow  (oOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    iData_flag = 1'b1;
    iData_in   = b;
    tick();
  endtask

  task automatic idle_cycle();
    iData_flag = 1'b0;
    iRelease   = 1'b0;
    tick();
  endtask

  task automatic check_all(input string tag, input logic [7:0] d, input logic [3:0] c,
                           input logic f, input logic fe, input logic ov);
    chk({tag, ".data"}, 64'(oData_out),  64'(d));
    chk({tag, ".cnt"},  64'(oCounter),   64'(c));
    chk({tag, ".full"}, 64'(oFull),      64'(f));
    chk({tag, ".ferr"}, 64'(oFrame_err), 64'(fe));
    chk({tag, ".ovf"},  64'(oOverflow),  64'(ov));
  endtask

  task automatic release_idle();
    iRelease   = 1'b1;
    iData_flag = 1'b0;
    tick();
    iRelease   = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    rst_n = 1'b0; ena = 1'b1; iData_in = 1'b0; iData_flag = 1'b0; iRelease = 1'b0;
    #23;
    check_all("reset", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Contiguous frame 0xA5
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      send(w[7-i]);
      chk("a5.cnt", 64'(oCounter), 64'(i + 1));
      chk("a5.full", 64'(oFull), (i == 7) ? 64'd1 : 64'd0);
    end
    check_all("a5.done", 8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) idle_cycle();
    check_all("a5.hold", 8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);

    // Overrun while FULL
    for (int i = 0; i < 3; i++) begin
      send(i[0]);
      check_all("ovf", 8'hA5, 4'd8, 1'b1, 1'b0, 1'b1);
    end
    release_idle();
    check_all("ovf.rel", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

    // Gap after five bits
    for (int i = 0; i < 5; i++) send(1'b1);
    chk("gap.cnt5", 64'(oCounter), 64'd5);
    idle_cycle();
    check_all("gap.pulse", 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
    idle_cycle();
    chk("gap.pulse_end", 64'(oFrame_err), 64'd0);

    w = 8'h3C;
    for (int i = 0; i < 8; i++) send(w[7-i]);
    check_all("3c", 8'h3C, 4'd8, 1'b1, 1'b0, 1'b0);

    // Release and new first bit in the same cycle
    iRelease = 1'b1;
    send(1'b1);
    iRelease = 1'b0;
    check_all("b2b.first", 8'h01, 4'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send(i == 6);
    check_all("b2b.word", 8'h81, 4'd8, 1'b1, 1'b0, 1'b0);
    release_idle();

    // Enable low mid-frame with the flag toggling
    w = 8'hB7;
    for (int i = 0; i < 3; i++) send(w[7-i]);
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iData_flag = i[0];
      iData_in   = ~i[0];
      iRelease   = 1'b1;
      tick();
      check_all("ena_off", 8'h05, 4'd3, 1'b0, 1'b0, 1'b0);
    end
    iRelease = 1'b0;
    ena = 1'b1;
    for (int i = 3; i < 8; i++) send(w[7-i]);
    check_all("ena.word", 8'hB7, 4'd8, 1'b1, 1'b0, 1'b0);
    release_idle();

    // Asynchronous reset at bit 4
    for (int i = 0; i < 4; i++) send(1'b1);
    chk("rst4.cnt", 64'(oCounter), 64'd4);
    iData_flag = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all("rst4.now", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("rst4.held", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    tick();

    // Asynchronous reset while FULL
    w = 8'h6E;
    for (int i = 0; i < 8; i++) send(w[7-i]);
    check_all("6e", 8'h6E, 4'd8, 1'b1, 1'b0, 1'b0);
    send(1'b1);
    chk("6e.ovf", 64'(oOverflow), 64'd1);
    iData_flag = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all("rstf.now", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("rstf.held", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    tick();

    w = 8'h5A;
    for (int i = 0; i < 8; i++) send(w[7-i]);
    check_all("after_rst", 8'h5A, 4'd8, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deserializer.md
# deserializer

Serial-to-parallel front end for the message path: samples one bit per clock while the upstream valid flag is high and assembles the bits MSB-first into a MSG_SIZE-bit word. It presents the word together with a bit counter, and that counter saturates at MSG_SIZE. The outputs drive the parallel-data and counter inputs of the downstream serializer. A completed word is held until the consumer releases it. Framing gaps and overruns are flagged, not silently absorbed.

## Interface
- MSG_SIZE, default 64: word width in bits; minimum 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  global enable; low freezes all state and outputs.
- iData_in  input  1  serial data bit, sampled when iData_flag=1.
- iData_flag  input  1  serial bit valid.
- iRelease  input  1  consumer done with held word; honoured only in FULL.
- oData_out  output  MSG_SIZE  assembled word; first received bit at MSB.
- oCounter  output  $clog2(MSG_SIZE)+1  number of bits accepted in current frame, 0..MSG_SIZE.
- oFull  output  1  high while a complete word is held (oCounter==MSG_SIZE).
- oFrame_err  output  1  one-cycle pulse: valid flag dropped mid-frame.
- oOverflow  output  1  sticky: valid bit arrived while FULL; cleared by release.

## Operation
- Reset (async, rst_n=0): state IDLE; oData_out=0, oCounter=0, oFull=0, oFrame_err=0, oOverflow=0.
- All transitions below require ena=1. With ena=0, every register holds its value, oFrame_err is forced 0, and iData_flag/iRelease are ignored. A flag low during ena=0 is not a gap.
- IDLE: iData_flag=1 -> oData_out <= {oData_out[MSG_SIZE-2:0], iData_in} (data is zero here), oCounter <= 1, go to SHIFT. Flag low -> stay.
- SHIFT, flag=1: shift left inserting iData_in at LSB; oCounter++. When the increment reaches MSG_SIZE -> FULL, and oFull goes high on the same edge.
- SHIFT, flag=0: oFrame_err=1 for one cycle, oData_out <= 0, oCounter <= 0, go to IDLE (partial word discarded).
- FULL: oData_out and oCounter (=MSG_SIZE) are held.
  - Flag=1 without release -> oOverflow <= 1; the bit is dropped and data is unchanged.
  - Flag=0 is not an error.
- FULL, iRelease=1, flag=0: oData_out <= 0, oCounter <= 0, oFull <= 0, oOverflow <= 0, go to IDLE.
- FULL, iRelease=1 and flag=1 in the same cycle: release wins, and the bit starts a new frame. oData_out <= {0..0, iData_in}, oCounter <= 1, oOverflow <= 0, go to SHIFT.
- iRelease in IDLE/SHIFT: ignored.
- oCounter never exceeds MSG_SIZE and never wraps.

## Timing
- All outputs are registered and update on the rising edge of clk, except the asynchronous reset.
- Latency:
  - Nth accepted bit is visible in oCounter=N after the edge that samples it.
  - Full word: oFull=1 and oCounter=MSG_SIZE after the edge sampling bit MSG_SIZE. That is MSG_SIZE cycles after the first flag-high sample for a contiguous frame.
- Throughput: one bit per cycle. A back-to-back next frame is possible by asserting iRelease in the same cycle as its first bit.
- Frame error: the pulse appears the cycle after the sampled gap, and lasts exactly one cycle.
- Reset mid-frame or in FULL: immediate clear to reset values; the next frame starts from IDLE.

## Test plan
- MSG_SIZE=8, contiguous flag with bits 1,0,1,0,0,1,0,1:
  - Required: oCounter steps 1..8.
  - Required: on the 8th edge, oData_out=0xA5 and oFull=1.
  - Required: values held for 20 idle cycles.
- FULL holding 0xA5, then 3 flagged bits, no release:
  - Required: oOverflow=1 from the first of them; data stays 0xA5; oCounter=8.
  - Then iRelease: all outputs return to 0.
- Flag low after 5 bits:
  - Required: oFrame_err high exactly one cycle; oCounter=0, oData_out=0.
  - Required: a following full frame of 0x3C assembles correctly.
- ena low for 4 cycles mid-frame, with the flag toggling:
  - Required: no state change and no oFrame_err.
  - Required: the frame resumes and completes with the correct word.
- In FULL, iRelease and flag=1 with bit 1 in the same cycle:
  - Required: oCounter=1, oData_out=0x01, oFull=0, oOverflow=0.
  - Required: the next 7 bits complete a new word.
- rst_n pulsed low asynchronously (between edges) at bit 4 and again in FULL:
  - Required: outputs are zero immediately and stay zero while reset is held.
